// File: rtl/mips_state_sequencer.sv
// Multi-cycle MIPS control sequencer: state register, opcode/funct entry decode,
// memory wait states with bounded MOC handshake, branch resolution and error states.
module mips_state_sequencer #(
  parameter int STATE_W     = 7,
  parameter int MOC_TIMEOUT = 15,
  parameter int ERR_HALT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               moc,
  input  logic               zero,
  output logic [STATE_W-1:0] state,
  output logic               mem_req,
  output logic               mem_rw,
  output logic               ir_load,
  output logic               pc_load,
  output logic               instr_done,
  output logic               illegal,
  output logic               bus_err
);

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_ADDU       = 5'd6,
    S_STORE      = 5'd7,
    S_STORE_WAIT = 5'd8,
    S_BEQ        = 5'd11,
    S_BEQ_TAKEN  = 5'd12,
    S_LOAD       = 5'd13,
    S_LOAD_WAIT  = 5'd14,
    S_LOAD_WB    = 5'd15,
    S_SUBU       = 5'd17,
    S_ILLEGAL    = 5'd20,
    S_BUSERR     = 5'd21
  } state_t;

  localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic             in_wait, at_limit;
  logic             unused_instr_bits;

  // Only opcode and funct steer the sequencer; the register fields belong to the datapath.
  assign unused_instr_bits = ^instr[25:6];

  function automatic state_t entry_state(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    case (op)
      6'h00:                      s = (fn == 6'h21) ? S_ADDU :
                                      (fn == 6'h23) ? S_SUBU : S_ILLEGAL;
      6'h28, 6'h29, 6'h2B:        s = S_STORE;
      6'h04:                      s = S_BEQ;
      6'h20, 6'h21, 6'h23,
      6'h24, 6'h25:               s = S_LOAD;
      default:                    s = S_ILLEGAL;
    endcase
    return s;
  endfunction

  assign in_wait  = cur inside {S_FETCH_WAIT, S_STORE_WAIT, S_LOAD_WAIT};
  // The cycle that would push the count to MOC_TIMEOUT is the last one allowed.
  assign at_limit = int'(cnt) >= MOC_TIMEOUT - 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= S_RESET;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      cur <= nxt;
      if (!in_wait)
        cnt <= '0;
      else if (!moc && int'(cnt) < MOC_TIMEOUT)
        cnt <= cnt + CNT_W'(1);
      if (nxt == S_BUSERR)
        bus_err <= 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_RESET:      nxt = S_FETCH;
      S_FETCH:      nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: if (moc) nxt = S_DECODE;    else if (at_limit) nxt = S_BUSERR;
      S_DECODE:     nxt = entry_state(instr[31:26], instr[5:0]);
      S_ADDU, S_SUBU, S_LOAD_WB, S_BEQ_TAKEN:
                    nxt = S_FETCH;
      S_STORE:      nxt = S_STORE_WAIT;
      S_STORE_WAIT: if (moc) nxt = S_FETCH;     else if (at_limit) nxt = S_BUSERR;
      S_LOAD:       nxt = S_LOAD_WAIT;
      S_LOAD_WAIT:  if (moc) nxt = S_LOAD_WB;   else if (at_limit) nxt = S_BUSERR;
      S_BEQ:        nxt = zero ? S_BEQ_TAKEN : S_FETCH;
      S_ILLEGAL, S_BUSERR:
                    nxt = (ERR_HALT != 0) ? cur : S_FETCH;
      default:      nxt = S_RESET;
    endcase
  end

  // instr_done must depend on moc/zero so it pulses once on the retiring cycle.
  always_comb begin
    state      = '0;
    state[4:0] = cur;
    mem_req    = cur inside {S_FETCH, S_FETCH_WAIT, S_LOAD, S_LOAD_WAIT, S_STORE, S_STORE_WAIT};
    mem_rw     = cur inside {S_STORE, S_STORE_WAIT};
    pc_load    = cur inside {S_DECODE, S_BEQ_TAKEN};
    illegal    = (cur == S_ILLEGAL);
    ir_load    = (cur == S_FETCH_WAIT) && moc;
    instr_done = (cur inside {S_ADDU, S_SUBU, S_LOAD_WB, S_BEQ_TAKEN}) ||
                 ((cur == S_STORE_WAIT) && moc) ||
                 ((cur == S_BEQ) && !zero);
  end

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Bench for mips_state_sequencer: instruction-level reference model driving directed
// and randomized transactions, plus a halting instance for terminal error states.
module tb_mips_state_sequencer;
  localparam int T  = 4;
  localparam int TH = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, moc, zero;
  logic [31:0] instr;
  logic [6:0]  st;
  logic        mreq, mrw, irl, pcl, done, ill, berr;

  logic        h_rst, h_moc, h_zero;
  logic [31:0] h_instr;
  logic [6:0]  h_st;
  logic        h_mreq, h_mrw, h_irl, h_pcl, h_done, h_ill, h_berr;

  int checks = 0;
  int errors = 0;
  bit sticky = 1'b0;

  mips_state_sequencer #(.STATE_W(7), .MOC_TIMEOUT(T), .ERR_HALT(0)) u_dut (
    .clk(clk), .reset(rst), .instr(instr), .moc(moc), .zero(zero), .state(st),
    .mem_req(mreq), .mem_rw(mrw), .ir_load(irl), .pc_load(pcl),
    .instr_done(done), .illegal(ill), .bus_err(berr));

  mips_state_sequencer u_halt (
    .clk(clk), .reset(h_rst), .instr(h_instr), .moc(h_moc), .zero(h_zero), .state(h_st),
    .mem_req(h_mreq), .mem_rw(h_mrw), .ir_load(h_irl), .pc_load(h_pcl),
    .instr_done(h_done), .illegal(h_ill), .bus_err(h_berr));

  typedef enum {K_ADDU, K_SUBU, K_STORE, K_LOAD, K_BEQ, K_ILL} kind_e;

  function automatic kind_e kind_of(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    if (op == 6'h00) return (ir[5:0] == 6'h21) ? K_ADDU : (ir[5:0] == 6'h23) ? K_SUBU : K_ILL;
    if (op inside {6'h28, 6'h29, 6'h2B}) return K_STORE;
    if (op == 6'h04) return K_BEQ;
    if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return K_LOAD;
    return K_ILL;
  endfunction

  function automatic logic x_mreq(input int s); return s inside {1, 2, 7, 8, 13, 14}; endfunction
  function automatic logic x_mrw(input int s);  return s inside {7, 8};              endfunction
  function automatic logic x_pcl(input int s);  return s inside {3, 12};             endfunction
  function automatic logic rb();                return 1'($urandom);                 endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_outs(input int es, input logic eir, input logic edn);
    chk("state",      32'(st),   32'(es));
    chk("mem_req",    32'(mreq), 32'(x_mreq(es)));
    chk("mem_rw",     32'(mrw),  32'(x_mrw(es)));
    chk("pc_load",    32'(pcl),  32'(x_pcl(es)));
    chk("illegal",    32'(ill),  32'(es == 20));
    chk("ir_load",    32'(irl),  32'(eir));
    chk("instr_done", 32'(done), 32'(edn));
    chk("bus_err",    32'(berr), 32'(sticky));
  endtask

  // One clock of the main instance: drive moc/zero, then check the expected state.
  task automatic cyc(input logic m, input logic z, input int es, input logic eir, input logic edn);
    @(negedge clk);
    moc  = m;
    zero = z;
    #1;
    if (es == 21) sticky = 1'b1;
    chk_outs(es, eir, edn);
  endtask

  // d idle cycles before moc; d >= T means the bus never answers in time.
  task automatic do_wait(input int ws, input int d, input logic eir, input logic edn, output bit err);
    err = (d >= T);
    for (int k = 0; k < (err ? T : d); k++) cyc(1'b0, rb(), ws, 1'b0, 1'b0);
    if (err) cyc(rb(), rb(), 21, 1'b0, 1'b0);
    else     cyc(1'b1, rb(), ws, eir, edn);
  endtask

  task automatic run_instr(input logic [31:0] ir, input int df, input int dm, input logic z);
    bit err;
    instr = ir;
    cyc(rb(), rb(), 1, 1'b0, 1'b0);
    do_wait(2, df, 1'b1, 1'b0, err);
    if (err) return;
    cyc(rb(), rb(), 3, 1'b0, 1'b0);
    case (kind_of(ir))
      K_ADDU:  cyc(rb(), rb(), 6, 1'b0, 1'b1);
      K_SUBU:  cyc(rb(), rb(), 17, 1'b0, 1'b1);
      K_STORE: begin
        cyc(rb(), rb(), 7, 1'b0, 1'b0);
        do_wait(8, dm, 1'b0, 1'b1, err);
      end
      K_LOAD: begin
        cyc(rb(), rb(), 13, 1'b0, 1'b0);
        do_wait(14, dm, 1'b0, 1'b0, err);
        if (!err) cyc(rb(), rb(), 15, 1'b0, 1'b1);
      end
      K_BEQ: begin
        cyc(rb(), z, 11, 1'b0, !z);
        if (z) cyc(rb(), rb(), 12, 1'b0, 1'b1);
      end
      default: cyc(rb(), rb(), 20, 1'b0, 1'b0);
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ir;
    int sel;
    ir  = $urandom;
    sel = $urandom_range(0, 4);
    case ($urandom_range(0, 7))
      0: begin ir[31:26] = 6'h00; ir[5:0] = 6'h21; end
      1: begin ir[31:26] = 6'h00; ir[5:0] = 6'h23; end
      2: ir[31:26] = 6'h00;
      3: ir[31:26] = 6'h04;
      4: ir[31:26] = (sel == 0) ? 6'h20 : (sel == 1) ? 6'h21 : (sel == 2) ? 6'h23 :
                     (sel == 3) ? 6'h24 : 6'h25;
      5: ir[31:26] = (sel < 2) ? 6'h28 : (sel < 4) ? 6'h29 : 6'h2B;
      default: ;
    endcase
    return ir;
  endfunction

  task automatic hcyc(input int es, input logic eir);
    @(negedge clk);
    #1;
    chk("h_state",   32'(h_st),   32'(es));
    chk("h_mem_req", 32'(h_mreq), 32'(x_mreq(es)));
    chk("h_mem_rw",  32'(h_mrw),  32'(x_mrw(es)));
    chk("h_pc_load", 32'(h_pcl),  32'(x_pcl(es)));
    chk("h_illegal", 32'(h_ill),  32'(es == 20));
    chk("h_bus_err", 32'(h_berr), 32'(es == 21));
    chk("h_ir_load", 32'(h_irl),  32'(eir));
    chk("h_done",    32'(h_done), 32'(0));
  endtask

  initial begin
    rst = 1'b1; moc = 1'b0; zero = 1'b0; instr = '0;
    h_rst = 1'b1; h_moc = 1'b0; h_zero = 1'b0; h_instr = '0;

    // Reset state, then RESET -> FETCH on the first clock after release.
    cyc(1'b1, 1'b1, 0, 1'b0, 1'b0);
    rst = 1'b0;
    #1 chk_outs(0, 1'b0, 1'b0);

    run_instr(32'h00851021, 0, 0, 1'b0);            // ADDU
    run_instr(32'h00851023, 1, 0, 1'b0);            // SUBU, delayed fetch
    run_instr(32'h8C880004, 0, 2, 1'b0);            // LW, delayed memory
    run_instr(32'hAC880004, 0, 1, 1'b0);            // SW
    run_instr(32'h10850003, 0, 0, 1'b1);            // BEQ taken
    run_instr(32'h10850003, 0, 0, 1'b0);            // BEQ not taken
    run_instr(32'h00851021, T - 1, 0, 1'b0);        // moc on the last allowed wait cycle
    run_instr(32'h00851021, T, 0, 1'b0);            // fetch timeout -> BUSERR
    run_instr(32'hAC880004, 0, T, 1'b0);            // store timeout -> BUSERR
    run_instr(32'hFC000000, 0, 0, 1'b0);            // illegal opcode, recovers
    run_instr(32'h00851020, 0, 0, 1'b0);            // illegal funct

    for (int n = 0; n < 200; n++)
      run_instr(rand_instr(), $urandom_range(0, 5), $urandom_range(0, 5), rb());

    // Asynchronous reset in the middle of a LOAD wait.
    run_instr(32'hAC880004, 0, 0, 1'b0);
    instr = 32'h8C880004;
    cyc(1'b1, 1'b0, 1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 13, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 14, 1'b0, 1'b0);
    rst = 1'b1;
    sticky = 1'b0;
    #1 chk_outs(0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    run_instr(32'h00851021, 0, 0, 1'b0);

    // Halting instance: illegal instruction is terminal until reset.
    h_instr = 32'hFC000000;
    h_moc = 1'b1;
    @(negedge clk);
    h_rst = 1'b0;
    hcyc(1, 1'b0);
    hcyc(2, 1'b1);
    hcyc(3, 1'b0);
    for (int k = 0; k < 4; k++) hcyc(20, 1'b0);
    h_rst = 1'b1;
    #1 chk("h_state_rst", 32'(h_st), 32'(0));
    chk("h_illegal_rst", 32'(h_ill), 32'(0));

    // Halting instance: bus never answers, BUSERR after TH wait cycles and holds.
    h_moc = 1'b0;
    @(negedge clk);
    h_rst = 1'b0;
    hcyc(1, 1'b0);
    for (int k = 0; k < TH; k++) hcyc(2, 1'b0);
    hcyc(21, 1'b0);
    h_moc = 1'b1;
    for (int k = 0; k < 3; k++) hcyc(21, 1'b0);
    h_rst = 1'b1;
    #1 chk("h_bus_err_rst", 32'(h_berr), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
